led_pattern_engine: RTL

Parametrised LED pattern generator that supersedes the fixed 8-bit switch-driven LED counter on the Genesys2 board. It has a runtime-programmable tick divider, eight pattern modes (count up/down, shift, rotate, invert, hold, bounce), a synchronised and debounced mode selector, and seed loading with enable. It sits directly behind the board clock buffer and drives the user LEDs; mode and enable come from slide switches, seed/load from buttons or a host register.

---
 rtl/led_pattern_engine.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/led_pattern_engine.sv
// led_pattern_engine
// LED pattern generator with a programmable tick divider, eight pattern
// modes, a synchronised and debounced mode selector and seed loading.
// All outputs come straight from flops; reset is synchronous, active-high.

module led_pattern_engine #(
    parameter int unsigned           LED_SIZE        = 8,
    parameter int unsigned           DIV_WIDTH       = 28,
    parameter int unsigned           DEBOUNCE_CYCLES = 1_000_000,
    parameter logic [LED_SIZE-1:0]   RESET_PATTERN   = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] period,
    input  logic [2:0]           mode,
    input  logic                 load,
    input  logic [LED_SIZE-1:0]  seed,
    output logic [LED_SIZE-1:0]  led_out,
    output logic                 tick,
    output logic [2:0]           mode_active
);

    // Pattern modes as seen on mode_active.
    typedef enum logic [2:0] {
        MODE_COUNT_UP    = 3'd0,
        MODE_HOLD        = 3'd1,
        MODE_SHIFT_LEFT  = 3'd2,
        MODE_SHIFT_RIGHT = 3'd3,
        MODE_INVERT      = 3'd4,
        MODE_COUNT_DOWN  = 3'd5,
        MODE_ROTATE_LEFT = 3'd6,
        MODE_BOUNCE      = 3'd7
    } pattern_mode_e;

    // Debounce counter only has to reach DEBOUNCE_CYCLES-1.
    localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // Divider state
    logic [DIV_WIDTH-1:0] r_div;
    logic                 r_tick;

    // Mode synchroniser and debounce state
    logic [2:0]           r_mode_s1;
    logic [2:0]           r_mode_s2;
    logic [2:0]           r_mode_s3;
    logic [DB_W-1:0]      r_db_cnt;
    logic [2:0]           r_mode_active;

    // Pattern state; r_dir_right=0 means the bounce is moving left (towards MSB)
    logic [LED_SIZE-1:0]  r_led;
    logic                 r_dir_right;

    // Next-pattern logic
    pattern_mode_e        w_mode;
    logic                 w_one_hot;
    logic [LED_SIZE-1:0]  w_next_led;
    logic                 w_next_dir_right;

    assign w_mode    = pattern_mode_e'(r_mode_active);
    assign w_one_hot = (r_led != '0) && ((r_led & (r_led - LED_SIZE'(1))) == '0);

    // Tick divider: wraps when the count reaches or passes period, so a
    // period lowered below the current count wraps on the very next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else if (enable) begin
            if (r_div >= period) begin
                r_div  <= '0;
                r_tick <= 1'b1;
            end else begin
                r_div  <= r_div + DIV_WIDTH'(1);
                r_tick <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    // Mode synchroniser and debounce: a value is applied only after it has
    // stayed stable on s2/s3 for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode_s1     <= '0;
            r_mode_s2     <= '0;
            r_mode_s3     <= '0;
            r_db_cnt      <= '0;
            r_mode_active <= '0;
        end else begin
            // NOTE: non-blocking assignments make this a real three-flop
            // chain; blocking ones would collapse it into a single stage.
            r_mode_s1 <= mode;
            r_mode_s2 <= r_mode_s1;
            r_mode_s3 <= r_mode_s2;
            if ((r_mode_s2 != r_mode_s3) || (r_mode_s2 == r_mode_active)) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_mode_active <= r_mode_s2;
                r_db_cnt      <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

    // Next pattern and bounce direction for the currently applied mode.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no
        // latch is inferred for the modes that leave the pattern alone.
        w_next_led       = r_led;
        w_next_dir_right = r_dir_right;
        case (w_mode)
            MODE_COUNT_UP:    w_next_led = r_led + LED_SIZE'(1);
            MODE_HOLD:        w_next_led = r_led;
            MODE_SHIFT_LEFT:  w_next_led = r_led << 1;
            MODE_SHIFT_RIGHT: w_next_led = r_led >> 1;
            MODE_INVERT:      w_next_led = ~r_led;
            MODE_COUNT_DOWN:  w_next_led = r_led - LED_SIZE'(1);
            MODE_ROTATE_LEFT: w_next_led = {r_led[LED_SIZE-2:0], r_led[LED_SIZE-1]};
            MODE_BOUNCE: begin
                if (!w_one_hot) begin
                    w_next_led       = LED_SIZE'(1);
                    w_next_dir_right = 1'b0;
                end else if (!r_dir_right && r_led[LED_SIZE-1]) begin
                    w_next_led       = r_led >> 1;
                    w_next_dir_right = 1'b1;
                end else if (r_dir_right && r_led[0]) begin
                    w_next_led       = r_led << 1;
                    w_next_dir_right = 1'b0;
                end else if (r_dir_right) begin
                    w_next_led       = r_led >> 1;
                end else begin
                    w_next_led       = r_led << 1;
                end
            end
            default: w_next_led = r_led;
        endcase
    end

    // Pattern register: load beats a same-cycle tick, whose step is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_led       <= RESET_PATTERN;
            r_dir_right <= 1'b0;
        end else if (load) begin
            r_led       <= seed;
            r_dir_right <= 1'b0;
        end else if (r_tick) begin
            r_led       <= w_next_led;
            r_dir_right <= w_next_dir_right;
        end
    end

    assign led_out     = r_led;
    assign tick        = r_tick;
    assign mode_active = r_mode_active;

endmodule
